dpram_port_arbiter: RTL and testbench

Shares the 4K x 64 dual-port RAM (dual_port_ram: wr, wr_add, in, rd, rd_add, out) between NUM_REQ requesters. Each RAM port has its own independent round-robin arbiter. The block registers the RAM-side control signals and routes each read result back to the requester that issued it. It also blocks same-cycle read/write collisions on the same address. It sits between client blocks and the DUV, and replaces direct per-port driving of the RAM.

---
 rtl/dpram_port_arbiter_pkg.sv | 16 +
 rtl/dpram_port_arbiter_if.sv | 36 +++
 rtl/dpram_port_arbiter_rr_arbiter.sv | 33 +++
 rtl/dpram_port_arbiter.sv | 123 ++++++++++++
 tb/tb_dpram_port_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_port_arbiter_pkg.sv
// Shared types for the dual-port RAM arbiter: width defaults, requester index
// and the read-tag pipeline entry that steers read data back to its requester.
package dpram_arb_pkg;

    localparam int ADDR_W_DEF  = 12;
    localparam int DATA_W_DEF  = 64;
    localparam int NUM_REQ_MAX = 8;

    typedef logic [$clog2(NUM_REQ_MAX)-1:0] req_idx_t;

    typedef struct packed {
        logic     valid;
        req_idx_t idx;
    } rd_tag_t;

endpackage

// File: rtl/dpram_port_arbiter_if.sv
// Client and RAM-side signal bundle of the arbiter. The slave modport is the
// arbiter's view; the master modport is the view of clients plus the RAM.
interface dpram_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 64
);
    // Request/grant: a requester holds req, addr and data stable until it sees
    // gnt in the same cycle; dropping req before that withdraws the request.
    logic [NUM_REQ-1:0]        wr_req;
    logic [NUM_REQ*ADDR_W-1:0] wr_addr;
    logic [NUM_REQ*DATA_W-1:0] wr_data;
    logic [NUM_REQ-1:0]        wr_gnt;
    logic [NUM_REQ-1:0]        rd_req;
    logic [NUM_REQ*ADDR_W-1:0] rd_addr;
    logic [NUM_REQ-1:0]        rd_gnt;
    logic [NUM_REQ-1:0]        rd_vld;
    logic [DATA_W-1:0]         rd_data;
    logic                      wr;
    logic [ADDR_W-1:0]         wr_add;
    logic [DATA_W-1:0]         in;
    logic                      rd;
    logic [ADDR_W-1:0]         rd_add;
    logic [DATA_W-1:0]         out;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, out,
        output wr_gnt, rd_gnt, rd_vld, rd_data, wr, wr_add, in, rd, rd_add
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, out,
        input  wr_gnt, rd_gnt, rd_vld, rd_data, wr, wr_add, in, rd, rd_add
    );

endinterface

// File: rtl/dpram_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr_i and wraps modulo N;
// next_ptr_o is one past the winner, or ptr_i when nothing is granted.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic             gnt_vld_o,
    output logic [PTR_W-1:0] gnt_idx_o,
    output logic [PTR_W-1:0] next_ptr_o
);

    always_comb begin
        int cand;
        gnt_o      = '0;
        gnt_vld_o  = 1'b0;
        gnt_idx_o  = '0;
        next_ptr_o = ptr_i;
        cand       = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr_i) + k) % N;
            if (!gnt_vld_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                gnt_vld_o   = 1'b1;
                gnt_idx_o   = PTR_W'(cand);
                next_ptr_o  = PTR_W'((cand + 1) % N);
            end
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one dual-port RAM between NUM_REQ clients: independent round-robin per
// port, registered RAM controls, and a tag pipeline that routes read data back.
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input logic        clk,
    input logic        rst,
    dpram_arb_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [ADDR_W-1:0] wr_addr_a [NUM_REQ];
    logic [DATA_W-1:0] wr_data_a [NUM_REQ];
    logic [ADDR_W-1:0] rd_addr_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign wr_addr_a[g] = bus.wr_addr[g*ADDR_W +: ADDR_W];
        assign wr_data_a[g] = bus.wr_data[g*DATA_W +: DATA_W];
        assign rd_addr_a[g] = bus.rd_addr[g*ADDR_W +: ADDR_W];
    end

    logic [NUM_REQ-1:0] wr_req_m, wr_gnt;
    logic [NUM_REQ-1:0] rd_req_m, rd_gnt;
    logic [NUM_REQ-1:0] collide;
    logic               wr_gnt_vld, rd_gnt_vld;
    logic [PTR_W-1:0]   wr_idx, rd_idx;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    logic               wr_q, rd_q;
    logic [ADDR_W-1:0]  wr_add_q, rd_add_q;
    logic [DATA_W-1:0]  wr_data_q;
    rd_tag_t            tag1_q, tag1_d, tag2_q;
    logic [NUM_REQ-1:0] rd_vld;

    assign wr_req_m = rst ? '0 : bus.wr_req;

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .req_i      (wr_req_m),
        .ptr_i      (wr_ptr_q),
        .gnt_o      (wr_gnt),
        .gnt_vld_o  (wr_gnt_vld),
        .gnt_idx_o  (wr_idx),
        .next_ptr_o (wr_ptr_d)
    );

    // A read hitting the address being written this cycle would race the RAM
    // write; hold it off one cycle so it sees the new data.
    always_comb begin
        collide = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            collide[i] = wr_gnt_vld && (rd_addr_a[i] == wr_addr_a[wr_idx]);
        end
    end

    assign rd_req_m = rst ? '0 : (bus.rd_req & ~collide);

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .req_i      (rd_req_m),
        .ptr_i      (rd_ptr_q),
        .gnt_o      (rd_gnt),
        .gnt_vld_o  (rd_gnt_vld),
        .gnt_idx_o  (rd_idx),
        .next_ptr_o (rd_ptr_d)
    );

    always_comb begin
        tag1_d       = '0;
        tag1_d.valid = rd_gnt_vld;
        tag1_d.idx   = req_idx_t'(rd_idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            wr_add_q  <= '0;
            rd_add_q  <= '0;
            wr_data_q <= '0;
            tag1_q    <= '0;
            tag2_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_q     <= wr_gnt_vld;
            rd_q     <= rd_gnt_vld;
            if (wr_gnt_vld) begin
                wr_add_q  <= wr_addr_a[wr_idx];
                wr_data_q <= wr_data_a[wr_idx];
            end
            if (rd_gnt_vld) begin
                rd_add_q <= rd_addr_a[rd_idx];
            end
            // Second tag stage lines up with the RAM's one-cycle read latency.
            tag1_q <= tag1_d;
            tag2_q <= tag1_q;
        end
    end

    always_comb begin
        rd_vld = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_vld[i] = tag2_q.valid && (tag2_q.idx == req_idx_t'(i));
        end
    end

    assign bus.wr_gnt  = wr_gnt;
    assign bus.rd_gnt  = rd_gnt;
    assign bus.rd_vld  = rd_vld;
    assign bus.rd_data = bus.out;
    assign bus.wr      = wr_q;
    assign bus.wr_add  = wr_add_q;
    assign bus.in      = wr_data_q;
    assign bus.rd      = rd_q;
    assign bus.rd_add  = rd_add_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: a vector table for arbitration order plus
// directed sequences for write/read, collision, pipelined reads and reset.
module tb_dpram_port_arbiter;
  import dpram_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 64;
  localparam int NV = 11;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dpram_arb_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  dpram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model: synchronous write, one-cycle registered read
  logic [DW-1:0] mem [4096];
  always @(posedge clk) begin
    if (bus.wr) mem[bus.wr_add] <= bus.in;
    if (bus.rd) bus.out <= mem[bus.rd_add];
  end

  typedef struct {
    logic [N-1:0] wr_req;
    logic [N-1:0] rd_req;
    logic [N-1:0] exp_wr;
    logic [N-1:0] exp_rd;
  } vec_t;

  vec_t          vecs [NV];
  logic [N-1:0]  exp_q [$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_addr[i*AW +: AW] = a;
    bus.wr_data[i*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    bus.rd_addr[i*AW +: AW] = a;
  endtask

  task automatic default_addrs();
    for (int i = 0; i < N; i++) begin
      set_wr(i, AW'(32'h100 + i), DW'(64'hA000 + i));
      set_rd(i, AW'(32'h200 + i));
    end
  endtask

  task automatic do_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    set_wr(i, a, d);
    bus.wr_req    = '0;
    bus.wr_req[i] = 1'b1;
    #1 chk("wr_gnt_single", bus.wr_gnt, DW'(N'(1) << i));
    @(posedge clk); #1;
    bus.wr_req = '0;
    chk("wr_after_gnt", bus.wr, 1);
    chk("wr_add_after_gnt", bus.wr_add, a);
    chk("in_after_gnt", bus.in, d);
  endtask

  task automatic do_read(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    set_rd(i, a);
    bus.rd_req    = '0;
    bus.rd_req[i] = 1'b1;
    #1 chk("rd_gnt_single", bus.rd_gnt, DW'(N'(1) << i));
    @(posedge clk); #1;
    bus.rd_req = '0;
    chk("rd_after_gnt", bus.rd, 1);
    chk("rd_add_after_gnt", bus.rd_add, a);
    chk("rd_vld_early", bus.rd_vld, 0);
    @(posedge clk); #1;
    chk("rd_vld_single", bus.rd_vld, DW'(N'(1) << i));
    chk("rd_data_single", bus.rd_data, d);
  endtask

  initial begin
    logic [N-1:0]  e;
    logic          wr_exp;
    logic [AW-1:0] wa_exp;
    logic [DW-1:0] in_exp;

    // row: wr_req, rd_req, expected wr_gnt, expected rd_gnt
    vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0000};
    vecs[1]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0000};
    vecs[2]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0000};
    vecs[3]  = '{4'b1111, 4'b0000, 4'b1000, 4'b0000};
    vecs[4]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0000};
    vecs[5]  = '{4'b0000, 4'b1010, 4'b0000, 4'b0010};
    vecs[6]  = '{4'b0000, 4'b1010, 4'b0000, 4'b1000};
    vecs[7]  = '{4'b1001, 4'b0101, 4'b1000, 4'b0001};
    vecs[8]  = '{4'b1001, 4'b0101, 4'b0001, 4'b0100};
    vecs[9]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[10] = '{4'b0000, 4'b0101, 4'b0000, 4'b0001};

    // clock/reset block
    rst = 1'b1;
    default_addrs();
    bus.wr_req = '1;
    bus.rd_req = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wr", bus.wr, 0);
    chk("reset_rd", bus.rd, 0);
    chk("reset_wr_add", bus.wr_add, 0);
    chk("reset_rd_add", bus.rd_add, 0);
    chk("reset_in", bus.in, 0);
    chk("reset_rd_vld", bus.rd_vld, 0);
    chk("reset_wr_gnt", bus.wr_gnt, 0);
    chk("reset_rd_gnt", bus.rd_gnt, 0);
    bus.wr_req = '0;
    bus.rd_req = '0;
    rst = 1'b0;

    // table-driven arbitration order, registered outputs one cycle later
    wr_exp = 1'b0;
    wa_exp = '0;
    in_exp = '0;
    for (int r = 0; r < NV + 2; r++) begin
      @(posedge clk); #1;
      chk("tbl_wr", bus.wr, wr_exp);
      chk("tbl_wr_add", bus.wr_add, wa_exp);
      chk("tbl_in", bus.in, in_exp);
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        chk("tbl_rd_vld", bus.rd_vld, e);
      end
      if (r < NV) begin
        bus.wr_req = vecs[r].wr_req;
        bus.rd_req = vecs[r].rd_req;
        #1;
        chk("tbl_wr_gnt", bus.wr_gnt, vecs[r].exp_wr);
        chk("tbl_rd_gnt", bus.rd_gnt, vecs[r].exp_rd);
        wr_exp = |vecs[r].exp_wr;
        for (int i = 0; i < N; i++) begin
          if (vecs[r].exp_wr[i]) begin
            wa_exp = AW'(32'h100 + i);
            in_exp = DW'(64'hA000 + i);
          end
        end
        exp_q.push_back(vecs[r].exp_rd);
      end else begin
        bus.wr_req = '0;
        bus.rd_req = '0;
        wr_exp = 1'b0;
        exp_q.push_back('0);
      end
    end

    // single write then read on a different requester
    do_write(1, 12'h123, 64'hDEAD_BEEF_0000_0001);
    do_read(2, 12'h123, 64'hDEAD_BEEF_0000_0001);

    // collision: same-cycle write and read of 0x0AA, write wins
    do_write(0, 12'h0AA, 64'h1111_1111_1111_1111);
    @(posedge clk); #1;
    set_wr(0, 12'h0AA, 64'h2222_3333_4444_5555);
    set_rd(3, 12'h0AA);
    bus.wr_req = 4'b0001;
    bus.rd_req = 4'b1000;
    #1;
    chk("coll_wr_gnt", bus.wr_gnt, 4'b0001);
    chk("coll_rd_gnt_blocked", bus.rd_gnt, 4'b0000);
    @(posedge clk); #1;
    bus.wr_req = '0;
    #1;
    chk("coll_rd_gnt_retry", bus.rd_gnt, 4'b1000);
    @(posedge clk); #1;
    bus.rd_req = '0;
    chk("coll_rd", bus.rd, 1);
    chk("coll_rd_vld_early", bus.rd_vld, 0);
    @(posedge clk); #1;
    chk("coll_rd_vld", bus.rd_vld, 4'b1000);
    chk("coll_rd_data", bus.rd_data, 64'h2222_3333_4444_5555);

    // pipelined reads after preloading 0x000..0x003
    for (int i = 0; i < N; i++) do_write(i, AW'(i), DW'(32'h10 + i));
    for (int c = 0; c < N + 2; c++) begin
      @(posedge clk); #1;
      if (c >= 2) begin
        chk("pipe_rd_vld", bus.rd_vld, DW'(N'(1) << (c - 2)));
        chk("pipe_rd_data", bus.rd_data, DW'(32'h10 + c - 2));
      end else begin
        chk("pipe_rd_vld_idle", bus.rd_vld, 0);
      end
      bus.rd_req = '0;
      if (c < N) begin
        set_rd(c, AW'(c));
        bus.rd_req[c] = 1'b1;
        #1 chk("pipe_rd_gnt", bus.rd_gnt, DW'(N'(1) << c));
      end
    end

    // reset while a read is in flight
    @(posedge clk); #1;
    set_rd(0, 12'h010);
    bus.rd_req = 4'b0001;
    #1 chk("rst_rd_gnt", bus.rd_gnt, 4'b0001);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_rd", bus.rd, 0);
    chk("rst_mid_wr", bus.wr, 0);
    chk("rst_mid_rd_vld", bus.rd_vld, 0);
    chk("rst_mid_rd_gnt", bus.rd_gnt, 0);
    @(posedge clk); #1;
    chk("rst_hold_rd_vld", bus.rd_vld, 0);
    chk("rst_hold_rd", bus.rd, 0);
    bus.rd_req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_rel_rd_vld", bus.rd_vld, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_after_rd_vld", bus.rd_vld, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
